// File: rtl/slip_rx.sv
// -----------------------------------------------------------------------------
// slip_rx : SLIP (RFC 1055) frame decoder for the firmware-update UART path.
//
// Takes raw UART bytes, strips END (0xC0) delimiters, undoes ESC (0xDB)
// sequences and presents decoded payload bytes on a valid/ready stream.
// It also reports good frames (with their decoded length) and aborted
// frames to the packet parser.
//
// Handshake rule (both streams): a byte moves on a rising clk edge where
// valid && ready are both high; valid never depends on ready.
//
// Parameters:
//   MAX_LEN  - maximum decoded payload bytes per frame (one more = error)
//   LEN_W    - width of the length counter / frame_len, must hold MAX_LEN
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_data/in_valid    - raw byte stream from the UART receiver
//   in_ready            - high only while the output register is empty
//   out_data/out_first  - decoded byte, out_first marks a frame's first byte
//   out_valid/out_ready - output stream handshake
//   frame_end           - one-cycle pulse, frame completed normally
//   frame_len           - decoded length of the last good frame (held)
//   frame_err           - one-cycle pulse, frame aborted
//   stat_frames/stat_errors - wrapping event counters, present only when
//                         SLIP_RX_STATS_EN is defined
//
// Optional feature macro: SLIP_RX_STATS_EN
// -----------------------------------------------------------------------------
module slip_rx #(
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_end,
  output logic [LEN_W-1:0] frame_len,
  output logic             frame_err
`ifdef SLIP_RX_STATS_EN
  ,
  output logic [15:0]      stat_frames,
  output logic [15:0]      stat_errors
`endif
);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_DATA = 2'd1,
    S_ESC  = 2'd2
  } state_t;

  localparam logic [7:0] END_B   = 8'hC0;
  localparam logic [7:0] ESC_B   = 8'hDB;
  localparam logic [7:0] ESC_END = 8'hDC;
  localparam logic [7:0] ESC_ESC = 8'hDD;
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  state_t           state_q,     state_d;
  logic [LEN_W-1:0] len_q,       len_d;
  logic [7:0]       out_data_q,  out_data_d;
  logic             out_first_q, out_first_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_end_q, frame_end_d;
  logic             frame_err_q, frame_err_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;

  logic       accept;
  logic       emit;
  logic [7:0] emit_byte;

  // Only accept while the output register is empty. This also guarantees
  // that an END is never consumed before the last payload byte has drained.
  assign in_ready = !out_valid_q;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    out_data_d  = out_data_q;
    out_first_d = out_first_q;
    out_valid_d = out_valid_q && !out_ready;
    frame_end_d = 1'b0;
    frame_err_d = 1'b0;
    frame_len_d = frame_len_q;
    emit        = 1'b0;
    emit_byte   = in_data;

    if (accept) begin
      case (state_q)
        S_HUNT: begin
          if (in_data == END_B) begin
            state_d = S_DATA;
            len_d   = '0;
          end
        end
        S_DATA: begin
          if (in_data == END_B) begin
            // Back-to-back ENDs (empty frames) are silently ignored.
            if (len_q != '0) begin
              frame_end_d = 1'b1;
              frame_len_d = len_q;
              len_d       = '0;
            end
          end else if (in_data == ESC_B) begin
            state_d = S_ESC;
          end else begin
            emit = 1'b1;
          end
        end
        S_ESC: begin
          if (in_data == ESC_END) begin
            emit      = 1'b1;
            emit_byte = END_B;
            state_d   = S_DATA;
          end else if (in_data == ESC_ESC) begin
            emit      = 1'b1;
            emit_byte = ESC_B;
            state_d   = S_DATA;
          end else if (in_data == END_B) begin
            // END right after ESC aborts but also opens a fresh frame.
            frame_err_d = 1'b1;
            len_d       = '0;
            state_d     = S_DATA;
          end else begin
            frame_err_d = 1'b1;
            len_d       = '0;
            state_d     = S_HUNT;
          end
        end
        default: state_d = S_HUNT;
      endcase

      if (emit) begin
        if (len_q == MAX_LEN_C) begin
          // Overflow: drop the byte, abort, wait for the next END.
          frame_err_d = 1'b1;
          len_d       = '0;
          state_d     = S_HUNT;
        end else begin
          out_data_d  = emit_byte;
          out_first_d = (len_q == '0);
          out_valid_d = 1'b1;
          len_d       = len_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HUNT;
      len_q       <= '0;
      out_data_q  <= '0;
      out_first_q <= 1'b0;
      out_valid_q <= 1'b0;
      frame_end_q <= 1'b0;
      frame_err_q <= 1'b0;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      out_data_q  <= out_data_d;
      out_first_q <= out_first_d;
      out_valid_q <= out_valid_d;
      frame_end_q <= frame_end_d;
      frame_err_q <= frame_err_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_first = out_first_q;
  assign out_valid = out_valid_q;
  assign frame_end = frame_end_q;
  assign frame_err = frame_err_q;
  assign frame_len = frame_len_q;

`ifdef SLIP_RX_STATS_EN
  logic [15:0] stat_frames_q, stat_frames_d;
  logic [15:0] stat_errors_q, stat_errors_d;

  // Counters follow the registered pulses and wrap naturally at 0xFFFF.
  always_comb begin
    stat_frames_d = stat_frames_q + {15'd0, frame_end_q};
    stat_errors_d = stat_errors_q + {15'd0, frame_err_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frames_q <= '0;
      stat_errors_q <= '0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_errors_q <= stat_errors_d;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_errors = stat_errors_q;
`endif

endmodule

// File: tb/tb_slip_rx.sv
// -----------------------------------------------------------------------------
// tb_slip_rx : self-checking bench for slip_rx (built with MAX_LEN = 4).
// A table of {reset, input byte, expected output/event} records is driven in
// order; expected bytes and frame events are queued as each byte is driven
// and popped when the DUT produces them. A hand-written sequence covers the
// output back-pressure case.
// -----------------------------------------------------------------------------
module tb_slip_rx;

  localparam int LEN_W = 11;
  localparam int MAXL  = 4;

  localparam logic [1:0] EV_NONE = 2'd0;
  localparam logic [1:0] EV_END  = 2'd1;
  localparam logic [1:0] EV_ERR  = 2'd2;

  typedef struct {
    logic             rst;
    logic [7:0]       b;
    logic             emit;
    logic [7:0]       d;
    logic             f;
    logic [1:0]       evt;
    logic [LEN_W-1:0] len;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       in_data = 8'h00;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       out_data;
  logic             out_first;
  logic             out_valid;
  logic             out_ready;
  logic             frame_end;
  logic [LEN_W-1:0] frame_len;
  logic             frame_err;
`ifdef SLIP_RX_STATS_EN
  logic [15:0]      stat_frames;
  logic [15:0]      stat_errors;
`endif

  always #5 clk = ~clk;

  logic rand_en   = 1'b0;
  logic ready_man = 1'b1;
  logic rnd_ready = 1'b1;

  always @(posedge clk) begin
    #2;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  assign out_ready = rand_en ? rnd_ready : ready_man;

  slip_rx #(.MAX_LEN(MAXL), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_end (frame_end),
    .frame_len (frame_len),
    .frame_err (frame_err)
`ifdef SLIP_RX_STATS_EN
    ,
    .stat_frames (stat_frames),
    .stat_errors (stat_errors)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int exp_frames = 0;
  int exp_errs   = 0;

  logic [8:0]  exp_q[$];   // {first, data}
  logic [12:0] evt_q[$];   // {event, len}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", {23'd0, out_first, out_data}, 32'h1ff);
        else check("out_byte", {23'd0, out_first, out_data}, {23'd0, exp_q.pop_front()});
      end
      if (frame_end && frame_err) check("end_and_err_together", 1, 0);
      if (frame_end) begin
        check("end_after_drain", exp_q.size(), 0);
        if (evt_q.size() == 0) check("unexpected_frame_end", 1, 0);
        else begin
          logic [12:0] e;
          e = evt_q.pop_front();
          check("event_kind_end", {30'd0, EV_END}, {30'd0, e[12:11]});
          check("frame_len", {21'd0, frame_len}, {21'd0, e[10:0]});
        end
      end
      if (frame_err) begin
        if (evt_q.size() == 0) check("unexpected_frame_err", 1, 0);
        else begin
          logic [12:0] e;
          e = evt_q.pop_front();
          check("event_kind_err", {30'd0, EV_ERR}, {30'd0, e[12:11]});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic vec_t mk(input logic rst, input logic [7:0] b, input logic emit,
                              input logic [7:0] d, input logic f, input logic [1:0] evt,
                              input int len);
    vec_t v;
    v.rst = rst; v.b = b; v.emit = emit; v.d = d; v.f = f; v.evt = evt;
    v.len = LEN_W'(len);
    return v;
  endfunction

  task automatic send_byte(input vec_t v);
    int guard;
    guard = 0;
    @(negedge clk); #1;
    if (v.emit) exp_q.push_back({v.f, v.d});
    if (v.evt != EV_NONE) begin
      evt_q.push_back({v.evt, v.len});
      if (v.evt == EV_END) exp_frames++;
      else exp_errs++;
    end
    in_data  = v.b;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 200) check("in_ready_timeout", 0, 1);
    else @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || evt_q.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    check("drain_bytes_left", exp_q.size(), 0);
    check("drain_events_left", evt_q.size(), 0);
    exp_q.delete();
    evt_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_first", out_first, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_in_ready", in_ready, 1);
`ifdef SLIP_RX_STATS_EN
    check("rst_stat_frames", stat_frames, 0);
    check("rst_stat_errors", stat_errors, 0);
`endif
    exp_frames = 0;
    exp_errs   = 0;
  endtask

  // ---------------- test ----------------
  vec_t tbl[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic frame
    tbl.push_back(mk(1, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h41, 1, 8'h41, 1, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h42, 1, 8'h42, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_END, 2));
    // escapes
    tbl.push_back(mk(1, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hDB, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hDC, 1, 8'hC0, 1, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hDB, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hDD, 1, 8'hDB, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h55, 1, 8'h55, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_END, 3));
    // garbage in hunt, repeated ENDs
    tbl.push_back(mk(1, 8'h11, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h22, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h7E, 1, 8'h7E, 1, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_END, 1));
    // bad escape -> hunt
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h01, 1, 8'h01, 1, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hDB, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h33, 0, 8'h00, 0, EV_ERR, 0));
    tbl.push_back(mk(0, 8'h02, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    // overflow at MAX_LEN = 4
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h01, 1, 8'h01, 1, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h02, 1, 8'h02, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h03, 1, 8'h03, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h04, 1, 8'h04, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h05, 0, 8'h00, 0, EV_ERR, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hAA, 1, 8'hAA, 1, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_END, 1));
    // lone ESC then END: error, but the END opens a new frame
    tbl.push_back(mk(0, 8'hDB, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_ERR, 0));
    tbl.push_back(mk(0, 8'h77, 1, 8'h77, 1, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_END, 1));
    // frame of exactly MAX_LEN bytes is good
    tbl.push_back(mk(0, 8'h01, 1, 8'h01, 1, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h02, 1, 8'h02, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h03, 1, 8'h03, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h04, 1, 8'h04, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_END, 4));
    // bad escape with no preceding data, discard until END
    tbl.push_back(mk(0, 8'hDB, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h41, 0, 8'h00, 0, EV_ERR, 0));
    tbl.push_back(mk(0, 8'h42, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    tbl.push_back(mk(0, 8'h43, 1, 8'h43, 1, EV_NONE, 0));
    tbl.push_back(mk(0, 8'hC0, 0, 8'h00, 0, EV_END, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) begin
        drain();
        do_reset();
        // first frame with a steady out_ready, later ones with random stalls
        rand_en = (i != 0);
      end
      send_byte(tbl[i]);
    end
    drain();
    check("held_frame_len", frame_len, 1);
`ifdef SLIP_RX_STATS_EN
    check("stat_frames_table", stat_frames, exp_frames);
    check("stat_errors_table", stat_errors, exp_errs);
`endif

    // back-pressure: 0x10 held for 10 cycles, nothing lost, END waits
    rand_en   = 1'b0;
    ready_man = 1'b0;
    send_byte(mk(0, 8'hC0, 0, 8'h00, 0, EV_NONE, 0));
    send_byte(mk(0, 8'h10, 1, 8'h10, 1, EV_NONE, 0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_data", out_data, 8'h10);
      check("stall_no_end", frame_end, 0);
    end
    ready_man = 1'b1;
    send_byte(mk(0, 8'h20, 1, 8'h20, 0, EV_NONE, 0));
    send_byte(mk(0, 8'hC0, 0, 8'h00, 0, EV_END, 2));
    drain();
    check("stall_frame_len", frame_len, 2);
`ifdef SLIP_RX_STATS_EN
    check("stat_frames_final", stat_frames, exp_frames);
    check("stat_errors_final", stat_errors, exp_errs);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/slip_rx.md
Name: slip_rx

Overview:
- SLIP (RFC 1055) frame decoder. Receive-side counterpart of the SLIP encoder on the firmware-update UART path.
- Consumes raw UART bytes, strips END delimiters, undoes ESC sequences, and emits decoded payload bytes on a valid/ready stream with first-byte marking.
- Reports frame completion, decoded length and aborted frames to the firmware-update packet parser.

Parameters:
- MAX_LEN, 1024: maximum decoded payload bytes per frame; one byte beyond this is an overflow error.
- LEN_W, 11: width of the length counter and `frame_len`; must hold MAX_LEN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  raw byte from UART receiver
- in_valid  in  1  in_data valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- out_data  out  8  decoded payload byte
- out_first  out  1  qualifies out_data as first byte of a frame
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- frame_end  out  1  one-cycle pulse: frame completed normally
- frame_len  out  LEN_W  decoded byte count of last good frame; held until next frame_end
- frame_err  out  1  one-cycle pulse: frame aborted

Behaviour:
- Reset values:
  - out_valid = 0, out_data = 0, out_first = 0
  - frame_end = 0, frame_err = 0, frame_len = 0
  - len = 0, state = S_HUNT
- Reset acts mid-frame with no flush.
- in_ready = !out_valid (registered). A byte is consumed only when the output register is empty.
- Output register: out_valid clears on out_valid && out_ready. A new byte loads the cycle after its input is accepted, so input-to-output latency is 1 cycle.
- Maximum throughput is one byte per 2 cycles.
- Ordering guarantee: END is consumed only after the last payload byte has drained. frame_end therefore never precedes the final byte's handshake.
- frame_end and frame_err are registered and assert the cycle after the causing byte is accepted.
- States and transitions on each accepted byte b:
  - S_HUNT:
    - b == 0xC0: go to S_DATA, len = 0.
    - Otherwise: discard, no pulses.
  - S_DATA:
    - b == 0xC0 and len == 0: ignore (empty frame or back-to-back END); stay.
    - b == 0xC0 and len != 0: frame_end pulse, frame_len <= len, len <= 0; stay.
    - b == 0xDB: go to S_ESC.
    - Otherwise: emit b.
  - S_ESC:
    - b == 0xDC: emit 0xC0, go to S_DATA.
    - b == 0xDD: emit 0xDB, go to S_DATA.
    - b == 0xC0: frame_err pulse, len = 0, go to S_DATA (END resynchronises; next frame starts clean).
    - Otherwise: frame_err pulse, len = 0, go to S_HUNT.
- Emit rules:
  - out_first = (len == 0); len <= len + 1.
  - If len == MAX_LEN: byte dropped, frame_err pulse, len = 0, go to S_HUNT. Nothing emitted.
- frame_err with len == 0 in S_ESC still pulses (lone ESC after END counts as an error).
- frame_end and frame_err are never asserted in the same cycle.
- A byte already in the output register stays valid when an error occurs. Downstream discards the partial frame on frame_err.

Optional Feature:
- Macro: SLIP_RX_STATS_EN.
- Defined:
  - Adds outputs `stat_frames` [15:0] and `stat_errors` [15:0].
  - Each increments on frame_end / frame_err respectively and wraps 0xFFFF -> 0.
  - Both reset to 0.
- Undefined: the ports and counters do not exist. Decode behaviour is identical.

Test Plan:
- Reset, then C0 41 42 C0 with out_ready = 1 -> out 0x41 (out_first = 1), 0x42 (out_first = 0); frame_end after 0x42 handshake; frame_len = 2.
- Reset, then C0 DB DC DB DD 55 C0 -> out C0, DB, 55; frame_len = 3; no frame_err.
- Garbage 11 22 then C0 C0 C0 7E C0 after reset -> 11/22 discarded; repeated C0 produce no pulses; single 0x7E out; frame_len = 1.
- C0 01 DB 33 02 C0 -> 0x01 out; frame_err pulse at 0x33; 02 discarded in S_HUNT; final C0 resyncs; no frame_end.
- MAX_LEN = 4: C0 plus 5 data bytes then C0 -> 4 bytes out; frame_err on 5th; no frame_end; next C0 AA C0 gives frame_len = 1.
- out_ready held low 10 cycles during C0 10 20 C0 -> in_ready low while 0x10 held; no byte loss; frame_end only after 0x20 accepted. With SLIP_RX_STATS_EN, stat_frames increments by 1.
